// File: rtl/apu_fpu_multiport_shim_pkg.sv
// Shared widths, flag layout and helpers for the APU-to-FPU shim.
package apu_fpu_shim_pkg;

  localparam int DATA_W      = 32;
  localparam int FLAGS_IN_W  = 15;
  localparam int FLAGS_OUT_W = 5;
  localparam int ID_W        = 9;

  typedef struct packed {
    logic [3:0] int_fmt;
    logic [3:0] src_fmt;
    logic [3:0] dst_fmt;
    logic [2:0] rnd_mode;
  } flags_t;

  function automatic int port_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apu_fpu_multiport_shim_if.sv
// APU request/response ports and FPU issue/result ports of the shim.
interface apu_fpu_multiport_shim_if
  import apu_fpu_shim_pkg::*;
#(
  parameter int NB_PORTS        = 4,
  parameter int ID_WIDTH        = ID_W,
  parameter int NB_ARGS         = 3,
  parameter int OPCODE_WIDTH    = 6,
  parameter int DATA_WIDTH      = DATA_W,
  parameter int FLAGS_IN_WIDTH  = FLAGS_IN_W,
  parameter int FLAGS_OUT_WIDTH = FLAGS_OUT_W
);
  localparam int TAG_W = port_w(NB_PORTS) + ID_WIDTH;

  logic [NB_PORTS-1:0]                 apu_req_i;
  logic [NB_PORTS-1:0]                 apu_gnt_o;
  logic [NB_PORTS-1:0][ID_WIDTH-1:0]   apu_ID_i;
  logic [NB_PORTS-1:0][NB_ARGS-1:0]
        [DATA_WIDTH-1:0]               apu_operands_i;
  logic [NB_PORTS-1:0][OPCODE_WIDTH-1:0] apu_op_i;
  logic [NB_PORTS-1:0]
        [FLAGS_IN_WIDTH-1:0]           apu_flags_i;
  logic [NB_PORTS-1:0]                 apu_rready_i;
  logic [NB_PORTS-1:0]                 apu_rvalid_o;
  logic [NB_PORTS-1:0][DATA_WIDTH-1:0] apu_rdata_o;
  logic [NB_PORTS-1:0]
        [FLAGS_OUT_WIDTH-1:0]          apu_rflags_o;
  logic [NB_PORTS-1:0][ID_WIDTH-1:0]   apu_rID_o;

  logic                                fpu_in_valid_o;
  logic                                fpu_in_ready_i;
  logic [NB_ARGS-1:0][DATA_WIDTH-1:0]  fpu_operands_o;
  logic [OPCODE_WIDTH-1:0]             fpu_op_o;
  logic [FLAGS_IN_WIDTH-1:0]           fpu_flags_o;
  logic [TAG_W-1:0]                    fpu_tag_o;
  logic                                fpu_out_valid_i;
  logic                                fpu_out_ready_o;
  logic [DATA_WIDTH-1:0]               fpu_result_i;
  logic [FLAGS_OUT_WIDTH-1:0]          fpu_status_i;
  logic [TAG_W-1:0]                    fpu_tag_i;
  logic                                busy_o;

  modport slave (
    input  apu_req_i, apu_ID_i, apu_operands_i,
    input  apu_op_i, apu_flags_i, apu_rready_i,
    input  fpu_in_ready_i, fpu_out_valid_i,
    input  fpu_result_i, fpu_status_i, fpu_tag_i,
    output apu_gnt_o, apu_rvalid_o, apu_rdata_o,
    output apu_rflags_o, apu_rID_o,
    output fpu_in_valid_o, fpu_operands_o, fpu_op_o,
    output fpu_flags_o, fpu_tag_o, fpu_out_ready_o,
    output busy_o
  );

  modport master (
    output apu_req_i, apu_ID_i, apu_operands_i,
    output apu_op_i, apu_flags_i, apu_rready_i,
    output fpu_in_ready_i, fpu_out_valid_i,
    output fpu_result_i, fpu_status_i, fpu_tag_i,
    input  apu_gnt_o, apu_rvalid_o, apu_rdata_o,
    input  apu_rflags_o, apu_rID_o,
    input  fpu_in_valid_o, fpu_operands_o, fpu_op_o,
    input  fpu_flags_o, fpu_tag_o, fpu_out_ready_o,
    input  busy_o
  );

endinterface

// File: rtl/apu_fpu_multiport_shim_resp_fifo.sv
// Registered in-order result FIFO; head is valid one cycle after push.
module apu_resp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]                 wr_ptr;
  logic [AW:0]                 rd_ptr;
  logic [DEPTH-1:0][WIDTH-1:0] mem;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW])
              && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      mem    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/apu_fpu_multiport_shim.sv
// Shares one FPU among NB_PORTS APU ports: round-robin issue,
// credit-limited outstanding ops, in-order tagged responses.
module apu_fpu_multiport_shim
  import apu_fpu_shim_pkg::*;
#(
  parameter int NB_PORTS        = 4,
  parameter int ID_WIDTH        = ID_W,
  parameter int NB_ARGS         = 3,
  parameter int OPCODE_WIDTH    = 6,
  parameter int DATA_WIDTH      = DATA_W,
  parameter int FLAGS_IN_WIDTH  = FLAGS_IN_W,
  parameter int FLAGS_OUT_WIDTH = FLAGS_OUT_W,
  parameter int RESP_DEPTH      = 4
) (
  input logic clk,
  input logic rst_n,
  apu_fpu_multiport_shim_if.slave bus
);
  localparam int PORT_W = port_w(NB_PORTS);
  localparam int TAG_W  = PORT_W + ID_WIDTH;
  localparam int CNT_W  = $clog2(RESP_DEPTH) + 1;
  localparam int ENT_W  = TAG_W + DATA_WIDTH + FLAGS_OUT_WIDTH;

  logic [CNT_W-1:0]  cnt;
  logic [PORT_W-1:0] rr_ptr;
  logic [PORT_W-1:0] win;
  logic              credit_ok;
  logic              issue;
  logic              pop;
  logic              full;
  logic              empty;
  logic [ENT_W-1:0]  head;
  logic [TAG_W-1:0]  head_tag;
  logic [PORT_W-1:0] head_port;

  function automatic logic [PORT_W-1:0] rr_pick(
    input logic [NB_PORTS-1:0] req,
    input logic [PORT_W-1:0]   ptr
  );
    logic [PORT_W-1:0] sel;
    logic              hit;
    int                k;
    sel = '0;
    hit = 1'b0;
    for (int i = 0; i < NB_PORTS; i++) begin
      k = (int'(ptr) + i) % NB_PORTS;
      if (!hit && req[k]) begin
        hit = 1'b1;
        sel = PORT_W'(k);
      end
    end
    return sel;
  endfunction

  // Credits only return on the registered count, keeping rready off the gnt path.
  assign credit_ok = (cnt < CNT_W'(RESP_DEPTH));
  assign win       = rr_pick(bus.apu_req_i, rr_ptr);
  assign issue     = bus.fpu_in_valid_o & bus.fpu_in_ready_i;

  assign bus.fpu_in_valid_o  = rst_n & (|bus.apu_req_i) & credit_ok;
  assign bus.fpu_operands_o  = bus.apu_operands_i[win];
  assign bus.fpu_op_o        = bus.apu_op_i[win];
  assign bus.fpu_flags_o     = bus.apu_flags_i[win];
  assign bus.fpu_tag_o       = {win, bus.apu_ID_i[win]};
  assign bus.fpu_out_ready_o = 1'b1;
  assign bus.busy_o          = (cnt != '0);

  always_comb begin
    bus.apu_gnt_o = '0;
    if (issue) bus.apu_gnt_o[win] = 1'b1;
  end

  apu_resp_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (RESP_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.fpu_out_valid_i),
    .pop   (pop),
    .din   ({bus.fpu_tag_i, bus.fpu_result_i,
             bus.fpu_status_i}),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  assign head_tag  = head[ENT_W-1 -: TAG_W];
  assign head_port = head_tag[TAG_W-1 -: PORT_W];
  assign pop       = !empty && bus.apu_rready_i[head_port];

  always_comb begin
    bus.apu_rvalid_o = '0;
    if (!empty) bus.apu_rvalid_o[head_port] = 1'b1;
  end

  always_comb begin
    for (int p = 0; p < NB_PORTS; p++) begin
      bus.apu_rdata_o[p]  = head[FLAGS_OUT_WIDTH +: DATA_WIDTH];
      bus.apu_rflags_o[p] = head[FLAGS_OUT_WIDTH-1:0];
      bus.apu_rID_o[p]    = head_tag[ID_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      rr_ptr <= '0;
    end else begin
      unique case (1'b1)
        issue && !pop: cnt <= cnt + 1'b1;
        pop && !issue: cnt <= cnt - 1'b1;
        default: ;
      endcase
      if (issue)
        rr_ptr <= (win == PORT_W'(NB_PORTS - 1)) ? '0 : win + 1'b1;
    end
  end

  overflow_chk: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(bus.fpu_out_valid_i && full && !pop)
  );

endmodule
